// File: rtl/register_file_2r1w.sv
`default_nettype none
// ============================================================================
// register_file_2r1w : DEPTH x WIDTH register file, byte-masked write port,
// two registered write-first read ports, per-entry valid bits.  Rev 1.0
// ============================================================================
module register_file_2r1w #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BYTES    = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTES-1:0]  wbe,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] rb,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  if (WIDTH % 8 != 0) begin : g_width_check
    $error("WIDTH must be a multiple of 8");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] byte_mask;
  logic [WIDTH-1:0] wr_merged;
  logic             wr_en;
  logic [WIDTH:0]   next_a;
  logic [WIDTH:0]   next_b;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      byte_mask[8*i +: 8] = {8{wbe[i]}};
    end
  end

  // Entry 0 is never written when hardwired, so its storage stays zero.
  assign wr_en = we && !clr && (|wbe) && ({1'b0, waddr} < DEPTH_EXT)
                 && !(ZERO_REG != 0 && waddr == '0);
  assign wr_merged = (mem[waddr] & ~byte_mask) | (wdata & byte_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (wr_en) begin
      mem[waddr]   <= wr_merged;
      valid[waddr] <= 1'b1;
    end
  end

  // Value an entry holds just after the current edge: {valid, data}.
  function automatic logic [WIDTH:0] post_edge(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    logic             vld;
    data = '0;
    vld  = 1'b0;
    if ({1'b0, addr} >= DEPTH_EXT) begin
      vld = 1'b0;
    end else if (ZERO_REG != 0 && addr == '0) begin
      vld = 1'b1;
    end else if (!clr) begin
      if (wr_en && waddr == addr) begin
        data = wr_merged;
        vld  = 1'b1;
      end else begin
        data = mem[addr];
        vld  = valid[addr];
      end
    end
    return {vld, data};
  endfunction

  always_comb begin
    next_a = post_edge(ra);
    next_b = post_edge(rb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      if (re_a) begin
        {rvalid_a, rdata_a} <= next_a;
      end
      if (re_b) begin
        {rvalid_b, rdata_b} <= next_b;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
`default_nettype none
// ============================================================================
// tb_register_file_2r1w : self-checking bench, default (DEPTH=8) and DEPTH=6
// instances sharing stimulus, checked against an array-based reference model.
// ============================================================================
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [2:0]  ra = '0;
  logic        re_b = 1'b0;
  logic [2:0]  rb = '0;

  logic [31:0] rdata_a8, rdata_b8, rdata_a6, rdata_b6;
  logic        rvalid_a8, rvalid_b8, rvalid_a6, rvalid_b6;

  always #5 clk = ~clk;

  register_file_2r1w #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .re_a(re_a), .ra(ra), .rdata_a(rdata_a8), .rvalid_a(rvalid_a8),
    .re_b(re_b), .rb(rb), .rdata_b(rdata_b8), .rvalid_b(rvalid_b8)
  );

  register_file_2r1w #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .re_a(re_a), .ra(ra), .rdata_a(rdata_a6), .rvalid_a(rvalid_a6),
    .re_b(re_b), .rb(rb), .rdata_b(rdata_b6), .rvalid_b(rvalid_b6)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
  logic [31:0] ref_mem [2][8];
  logic        ref_vld [2][8];
  logic [31:0] exp_da [2];
  logic [31:0] exp_db [2];
  logic        exp_va [2];
  logic        exp_vb [2];

  wire [31:0] got_da [2];
  wire [31:0] got_db [2];
  wire        got_va [2];
  wire        got_vb [2];
  assign got_da[0] = rdata_a8;  assign got_da[1] = rdata_a6;
  assign got_db[0] = rdata_b8;  assign got_db[1] = rdata_b6;
  assign got_va[0] = rvalid_a8; assign got_va[1] = rvalid_a6;
  assign got_vb[0] = rvalid_b8; assign got_vb[1] = rvalid_b6;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) begin
        ref_mem[k][j] = '0;
        ref_vld[k][j] = 1'b0;
      end
      exp_da[k] = '0; exp_db[k] = '0;
      exp_va[k] = 1'b0; exp_vb[k] = 1'b0;
    end
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0; wbe = '0;
  endtask

  // Advance one rising edge, apply the storage rules, then look up what each
  // enabled read port should now show.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int d;
      d = (k == 0) ? 8 : 6;
      if (clr) begin
        for (int j = 0; j < 8; j++) begin
          ref_mem[k][j] = '0;
          ref_vld[k][j] = 1'b0;
        end
      end else if (we && int'(waddr) < d && waddr != 3'd0 && wbe != 4'd0) begin
        for (int b = 0; b < 4; b++) begin
          if (wbe[b]) ref_mem[k][waddr][8*b +: 8] = wdata[8*b +: 8];
        end
        ref_vld[k][waddr] = 1'b1;
      end
      if (re_a) begin
        if (int'(ra) >= d)  begin exp_da[k] = '0; exp_va[k] = 1'b0; end
        else if (ra == 3'd0) begin exp_da[k] = '0; exp_va[k] = 1'b1; end
        else begin exp_da[k] = ref_mem[k][ra]; exp_va[k] = ref_vld[k][ra]; end
      end
      if (re_b) begin
        if (int'(rb) >= d)  begin exp_db[k] = '0; exp_vb[k] = 1'b0; end
        else if (rb == 3'd0) begin exp_db[k] = '0; exp_vb[k] = 1'b1; end
        else begin exp_db[k] = ref_mem[k][rb]; exp_vb[k] = ref_vld[k][rb]; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rvalid_a8, rdata_a8, rvalid_b8, rdata_b8} !== 66'd0) begin
      failures++;
      $display("FAIL reset_init got a=%h/%b b=%h/%b exp 0/0", rdata_a8, rvalid_a8, rdata_b8, rvalid_b8);
    end
    rst_n = 1'b1;
    we = 1'b1; waddr = 3'd3; wbe = 4'hF; wdata = 32'hDEADBEEF;
    re_a = 1'b1; ra = 3'd3; re_b = 1'b1; rb = 3'd3;
    tick();
    checks++;
    if (rdata_a8 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_prewrite got %h exp deadbeef", rdata_a8);
    end
    // Assert reset mid-cycle with a write still pending.
    we = 1'b1; waddr = 3'd3; wdata = 32'h11111111;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rvalid_a8, rdata_a8, rvalid_b8, rdata_b8} !== 66'd0) begin
      failures++;
      $display("FAIL reset_async got a=%h/%b b=%h/%b exp 0/0", rdata_a8, rvalid_a8, rdata_b8, rvalid_b8);
    end
    idle();
    #1 rst_n = 1'b1;
    re_a = 1'b1; ra = 3'd3;
    tick();
    checks++;
    if (rdata_a8 !== 32'h0 || rvalid_a8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_entry3 got %h/%b exp 00000000/0", rdata_a8, rvalid_a8);
    end
    idle();
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 3'd2; wbe = 4'hF; wdata = 32'hFFFFFFFF;
    tick();
    idle();
    re_a = 1'b1; ra = 3'd2;
    tick();
    checks++;
    if (rdata_a8 !== 32'hFFFFFFFF || rvalid_a8 !== 1'b1) begin
      failures++;
      $display("FAIL write_read got %h/%b exp ffffffff/1", rdata_a8, rvalid_a8);
    end
    idle();
  endtask

  task automatic test_byte_mask();
    we = 1'b1; waddr = 3'd2; wbe = 4'b0101; wdata = 32'h80000801;
    tick();
    idle();
    re_b = 1'b1; rb = 3'd2;
    tick();
    checks++;
    if (rdata_b8 !== 32'hFF00FF01 || rvalid_b8 !== 1'b1) begin
      failures++;
      $display("FAIL byte_mask got %h/%b exp ff00ff01/1", rdata_b8, rvalid_b8);
    end
    // Partial write bypassed on the same edge: merged bytes must appear.
    we = 1'b1; waddr = 3'd2; wbe = 4'b0010; wdata = 32'h00003400;
    re_b = 1'b1; rb = 3'd2;
    tick();
    checks++;
    if (rdata_b8 !== 32'hFF003401) begin
      failures++;
      $display("FAIL bypass_merge got %h exp ff003401", rdata_b8);
    end
    // wbe=0 is a no-op even with we=1.
    we = 1'b1; waddr = 3'd6; wbe = 4'h0; wdata = 32'h12121212;
    re_a = 1'b1; ra = 3'd6; re_b = 1'b0;
    tick();
    checks++;
    if (rdata_a8 !== 32'h0 || rvalid_a8 !== 1'b0) begin
      failures++;
      $display("FAIL wbe_zero got %h/%b exp 00000000/0", rdata_a8, rvalid_a8);
    end
    idle();
  endtask

  task automatic test_bypass_hold();
    we = 1'b1; waddr = 3'd5; wbe = 4'hF; wdata = 32'hAAAAAAAA;
    re_a = 1'b1; ra = 3'd5;
    tick();
    checks++;
    if (rdata_a8 !== 32'hAAAAAAAA || rvalid_a8 !== 1'b1) begin
      failures++;
      $display("FAIL bypass got %h/%b exp aaaaaaaa/1", rdata_a8, rvalid_a8);
    end
    idle();
    re_a = 1'b0; ra = 3'd1;
    tick();
    checks++;
    if (rdata_a8 !== 32'hAAAAAAAA || rvalid_a8 !== 1'b1) begin
      failures++;
      $display("FAIL hold got %h/%b exp aaaaaaaa/1", rdata_a8, rvalid_a8);
    end
    re_a = 1'b1; ra = 3'd5; re_b = 1'b1; rb = 3'd5;
    tick();
    checks++;
    if (rdata_a8 !== 32'hAAAAAAAA || rdata_b8 !== 32'hAAAAAAAA || rvalid_b8 !== 1'b1) begin
      failures++;
      $display("FAIL dual_same got a=%h b=%h/%b exp aaaaaaaa/1", rdata_a8, rdata_b8, rvalid_b8);
    end
    idle();
  endtask

  task automatic test_zero_clear();
    we = 1'b1; waddr = 3'd0; wbe = 4'hF; wdata = 32'h12345678;
    tick();
    idle();
    re_a = 1'b1; ra = 3'd0;
    tick();
    checks++;
    if (rdata_a8 !== 32'h0 || rvalid_a8 !== 1'b1) begin
      failures++;
      $display("FAIL zero_reg got %h/%b exp 00000000/1", rdata_a8, rvalid_a8);
    end
    clr = 1'b1; we = 1'b1; waddr = 3'd4; wbe = 4'hF; wdata = 32'h5;
    re_b = 1'b1; rb = 3'd4; re_a = 1'b1; ra = 3'd5;
    tick();
    checks++;
    if (rdata_b8 !== 32'h0 || rvalid_b8 !== 1'b0) begin
      failures++;
      $display("FAIL clr_wins got %h/%b exp 00000000/0", rdata_b8, rvalid_b8);
    end
    checks++;
    if (rdata_a8 !== 32'h0 || rvalid_a8 !== 1'b0) begin
      failures++;
      $display("FAIL clr_bypass got %h/%b exp 00000000/0", rdata_a8, rvalid_a8);
    end
    idle();
    re_b = 1'b1; rb = 3'd4; re_a = 1'b1; ra = 3'd0;
    tick();
    checks++;
    if (rdata_b8 !== 32'h0 || rvalid_b8 !== 1'b0) begin
      failures++;
      $display("FAIL clr_entry4 got %h/%b exp 00000000/0", rdata_b8, rvalid_b8);
    end
    checks++;
    if (rdata_a8 !== 32'h0 || rvalid_a8 !== 1'b1) begin
      failures++;
      $display("FAIL zero_after_clr got %h/%b exp 00000000/1", rdata_a8, rvalid_a8);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    we = 1'b1; waddr = 3'd5; wbe = 4'hF; wdata = 32'h000000AB;
    tick();
    we = 1'b1; waddr = 3'd7; wbe = 4'hF; wdata = 32'h00000001;
    tick();
    idle();
    for (int j = 1; j < 6; j++) begin
      re_a = 1'b1; ra = 3'(j);
      tick();
      checks++;
      if (rdata_a6 !== exp_da[1] || rvalid_a6 !== exp_va[1]) begin
        failures++;
        $display("FAIL oor_entry%0d got %h/%b exp %h/%b", j, rdata_a6, rvalid_a6, exp_da[1], exp_va[1]);
      end
    end
    checks++;
    if (rdata_a6 !== 32'h000000AB || rvalid_a6 !== 1'b1) begin
      failures++;
      $display("FAIL last_entry got %h/%b exp 000000ab/1", rdata_a6, rvalid_a6);
    end
    re_a = 1'b1; ra = 3'd6; re_b = 1'b1; rb = 3'd7;
    tick();
    checks++;
    if (rdata_a6 !== 32'h0 || rvalid_a6 !== 1'b0 || rdata_b6 !== 32'h0 || rvalid_b6 !== 1'b0) begin
      failures++;
      $display("FAIL oor_read got a=%h/%b b=%h/%b exp 0/0", rdata_a6, rvalid_a6, rdata_b6, rvalid_b6);
    end
    checks++;
    if (rdata_b8 !== 32'h00000001 || rvalid_b8 !== 1'b1) begin
      failures++;
      $display("FAIL depth8_entry7 got %h/%b exp 00000001/1", rdata_b8, rvalid_b8);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr   = ($urandom_range(0, 31) == 0);
      we    = $urandom_range(0, 1);
      waddr = 3'($urandom_range(0, 7));
      wbe   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      wdata = $urandom;
      re_a  = ($urandom_range(0, 3) != 0);
      ra    = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
      re_b  = ($urandom_range(0, 3) != 0);
      rb    = ($urandom_range(0, 4) == 0) ? ra : 3'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_da[k] !== exp_da[k] || got_va[k] !== exp_va[k]) begin
          failures++;
          $display("FAIL rand_a inst%0d cyc%0d got %h/%b exp %h/%b", k, c, got_da[k], got_va[k], exp_da[k], exp_va[k]);
        end
        checks++;
        if (got_db[k] !== exp_db[k] || got_vb[k] !== exp_vb[k]) begin
          failures++;
          $display("FAIL rand_b inst%0d cyc%0d got %h/%b exp %h/%b", k, c, got_db[k], got_vb[k], exp_db[k], exp_vb[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_byte_mask();
    test_bypass_hold();
    test_zero_clear();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised multi-entry register file: DEPTH words of WIDTH bits, one write port with byte enables, two independent read ports.
- Reads are registered with write-first bypass. Each entry carries a valid bit.
- Datapath storage block for the upcoming processor datapath. Generalises the single 32-bit enable-gated register to multiple entries, with reset, clear and byte-granular writes.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8; BYTES = WIDTH/8
DEPTH, 8, number of entries; any value >= 2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
ZERO_REG, 1, 1 = entry 0 is hardwired to zero, always valid, writes to it ignored

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all entries and valid bits
we  input  1  write enable
waddr  input  ADDR_W  write address
wbe  input  BYTES  byte write enables (bit i covers wdata[8i+7:8i])
wdata  input  WIDTH  write data
re_a  input  1  read enable, port A
ra  input  ADDR_W  read address, port A
rdata_a  output  WIDTH  registered read data, port A
rvalid_a  output  1  valid bit of entry read on port A
re_b  input  1  read enable, port B
rb  input  ADDR_W  read address, port B
rdata_b  output  WIDTH  registered read data, port B
rvalid_b  output  1  valid bit of entry read on port B

Behaviour:
- Reset: rst_n low asynchronously forces all entries, all valid bits, rdata_a/b and rvalid_a/b to 0. Takes effect immediately, including mid-write; no partial update survives. First update after release is the next rising clk edge.
- Write, on posedge with we=1, clr=0, waddr<DEPTH:
  - Bytes with wbe[i]=1 take wdata bytes; other bytes keep their old value.
  - valid[waddr] set to 1 if wbe != 0.
  - we=1 with wbe=0 is a no-op.
- Writes to waddr>=DEPTH are ignored. Writes to entry 0 are ignored when ZERO_REG=1.
- Clear, on posedge with clr=1: all entries and valid bits go to 0; the write in the same cycle is discarded (clr wins).
- Read, per port, independent: on posedge with re_x=1, rdata_x/rvalid_x load the entry's post-edge value (write-first).
  - Same-cycle write to the same address: the merged bytes (new bytes where wbe=1, old bytes elsewhere) and valid=1 appear at the output.
  - Same-cycle clr: output is 0 with valid 0.
  - Latency: 1 cycle from address to output.
- re_x=0: rdata_x/rvalid_x hold their previous value.
- Read address >= DEPTH: rdata_x=0, rvalid_x=0.
- ZERO_REG=1: a read of entry 0 returns rdata=0, rvalid=1, including after clr. This applies to reads; the reset values of the output registers are still 0.
- Both ports may read the same address in the same cycle; both return identical values.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing 0xDEADBEEF to entry 3 -> rdata_a/b=0 and rvalid=0 immediately; after release, read entry 3 -> 0x00000000, rvalid=0.
- Write then read: write 0xFFFFFFFF to entry 2 with wbe=4'hF; next cycle read ra=2 -> rdata_a=0xFFFFFFFF, rvalid_a=1 one cycle later.
- Byte mask: entry 2=0xFFFFFFFF, write 0x80000801 with wbe=4'b0101 -> entry 2 reads 0xFF00FF01.
- Bypass and hold:
  - Same cycle: write 0xAAAAAAAA to entry 5 (wbe=4'hF) with ra=5, re_a=1 -> rdata_a=0xAAAAAAAA after that edge.
  - Next cycle: re_a=0, ra=1 -> rdata_a stays 0xAAAAAAAA.
- Zero register and clear:
  - Write 0x12345678 to entry 0 -> reads 0, rvalid=1.
  - clr=1 with a simultaneous write of 0x5 to entry 4 and rb=4 -> rdata_b=0, rvalid_b=0; entry 4 remains 0 afterwards.
- Out-of-range: instance with DEPTH=6; write 0x1 to address 7 -> no entry changes; read address 6 -> rdata=0, rvalid=0.
